alarm_unit: RTL and testbench

- Settable daily alarm driven by the 24-hour clock's packed time word.
- Holds an alarm hour/minute set from the shared add_one/add_ten/hr_sw/min_sw controls, and arms on operator request.
- Raises ringing and beep when the clock reaches the alarm minute; supports snooze, dismiss and auto-timeout.
- Exports the alarm setting in the same 27-bit packed format as the clock outputs, so the display mux/BCD path can consume it.

---
 rtl/alarm_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_alarm_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_unit.sv
// alarm_unit
// Settable daily alarm driven by the 24-hour clock's packed time word.
// The alarm hour/minute are set from the shared add_one/add_ten controls
// while idle, the alarm arms on request, rings with a square-wave beep when
// the clock enters the alarm minute, and supports snooze, dismiss and an
// automatic timeout after a number of unattended minutes.
//
// Ports:
//   clk        in   clock shared with the 12/24-hour clocks
//   reset      in   synchronous, active-high reset
//   cur_time   in   27-bit packed time {hr[26:22], min[21:16], sec, frac, sub}
//   set_en     in   level, alarm-setting mode (only honoured while IDLE)
//   add_one    in   debounced level, rising edge adds 1 to selected field
//   add_ten    in   debounced level, rising edge adds 10 to selected field
//   hr_sw      in   selects hour field (priority over min_sw)
//   min_sw     in   selects minute field
//   arm        in   level, alarm enabled
//   snooze     in   debounced level, acts on rising edge
//   dismiss    in   debounced level, acts on rising edge
//   alarm_time out  {al_hr, al_min, 16'b0}, same packing as cur_time
//   armed      out  state != IDLE
//   ringing    out  state == RINGING
//   beep       out  square wave while RINGING, else 0
//   state      out  IDLE=0, ARMED=1, RINGING=2, SNOOZED=3
module alarm_unit #(
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int BEEP_HALF        = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] cur_time,
    input  logic        set_en,
    input  logic        add_one,
    input  logic        add_ten,
    input  logic        hr_sw,
    input  logic        min_sw,
    input  logic        arm,
    input  logic        snooze,
    input  logic        dismiss,
    output logic [26:0] alarm_time,
    output logic        armed,
    output logic        ringing,
    output logic        beep,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } state_t;

    localparam int BW = $clog2(BEEP_HALF + 1);

    state_t        state_q, state_d;
    logic [4:0]    al_hr_q, al_hr_d;
    logic [5:0]    al_min_q, al_min_d;
    logic          add_one_q, add_one_d;
    logic          add_ten_q, add_ten_d;
    logic          snooze_q, snooze_d;
    logic          dismiss_q, dismiss_d;
    logic          match_q, match_d;
    logic [5:0]    prev_min_q, prev_min_d;
    logic [4:0]    ring_cnt_q, ring_cnt_d;
    logic [4:0]    snz_cnt_q, snz_cnt_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          beep_q, beep_d;

    logic          add_one_edge, add_ten_edge, snooze_edge, dismiss_edge;
    logic          match, trigger, min_tick;
    logic [3:0]    inc;
    logic [5:0]    hr_sum;
    logic [6:0]    min_sum;
    logic [4:0]    ring_cnt_inc;
    logic          unused_time_bits;

    // Seconds and sub-second fields are irrelevant to a minute-resolution alarm.
    assign unused_time_bits = ^cur_time[15:0];

    assign add_one_edge = add_one & ~add_one_q;
    assign add_ten_edge = add_ten & ~add_ten_q;
    assign snooze_edge  = snooze  & ~snooze_q;
    assign dismiss_edge = dismiss & ~dismiss_q;

    // The trigger fires only on entry into the alarm minute, so a forward or
    // backward time jump that lands inside the minute still rings exactly once.
    assign match    = (cur_time[26:22] == al_hr_q) && (cur_time[21:16] == al_min_q);
    assign trigger  = match & ~match_q;
    assign min_tick = (cur_time[21:16] != prev_min_q);

    // Increment is at most 11, so a single conditional subtract gives the modulus.
    assign inc          = (add_one_edge ? 4'd1 : 4'd0) + (add_ten_edge ? 4'd10 : 4'd0);
    assign hr_sum       = {1'b0, al_hr_q} + {2'b00, inc};
    assign min_sum      = {1'b0, al_min_q} + {3'b000, inc};
    assign ring_cnt_inc = ring_cnt_q + 5'd1;

    // Alarm setting, edge history and next-state logic.
    always_comb begin
        add_one_d  = add_one;
        add_ten_d  = add_ten;
        snooze_d   = snooze;
        dismiss_d  = dismiss;
        match_d    = match;
        prev_min_d = cur_time[21:16];
        al_hr_d    = al_hr_q;
        al_min_d   = al_min_q;
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        beep_cnt_d = beep_cnt_q;
        beep_d     = beep_q;

        if (state_q == IDLE && set_en) begin
            if (hr_sw) begin
                al_hr_d = (hr_sum >= 6'd24) ? 5'(hr_sum - 6'd24) : hr_sum[4:0];
            end else if (min_sw) begin
                al_min_d = (min_sum >= 7'd60) ? 6'(min_sum - 7'd60) : min_sum[5:0];
            end
        end

        if (!arm) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
            beep_cnt_d = '0;
            beep_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!set_en) state_d = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        beep_cnt_d = '0;
                        beep_d     = 1'b1;
                    end
                end
                RINGING: begin
                    if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
                        beep_cnt_d = '0;
                        beep_d     = ~beep_q;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 1'b1;
                    end
                    if (dismiss_edge) begin
                        state_d = ARMED;
                    end else if (snooze_edge) begin
                        state_d   = SNOOZED;
                        snz_cnt_d = 5'(SNOOZE_MIN);
                    end else if (min_tick) begin
                        ring_cnt_d = ring_cnt_inc;
                        if (ring_cnt_inc == 5'(RING_TIMEOUT_MIN)) state_d = ARMED;
                    end
                end
                SNOOZED: begin
                    if (dismiss_edge) begin
                        state_d = ARMED;
                    end else if (min_tick) begin
                        snz_cnt_d = snz_cnt_q - 5'd1;
                        if (snz_cnt_q == 5'd1) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                            beep_cnt_d = '0;
                            beep_d     = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Any exit from RINGING silences the beep and rewinds its timers.
        if (state_d != RINGING) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
            ring_cnt_d = '0;
        end
    end

    // State register; edge histories and match_q reset high so an input held
    // through reset produces no spurious edge or trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            al_hr_q    <= '0;
            al_min_q   <= '0;
            add_one_q  <= 1'b1;
            add_ten_q  <= 1'b1;
            snooze_q   <= 1'b1;
            dismiss_q  <= 1'b1;
            match_q    <= 1'b1;
            prev_min_q <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            al_hr_q    <= al_hr_d;
            al_min_q   <= al_min_d;
            add_one_q  <= add_one_d;
            add_ten_q  <= add_ten_d;
            snooze_q   <= snooze_d;
            dismiss_q  <= dismiss_d;
            match_q    <= match_d;
            prev_min_q <= prev_min_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
        end
    end

    assign alarm_time = {al_hr_q, al_min_q, 16'b0};
    assign armed      = (state_q != IDLE);
    assign ringing    = (state_q == RINGING);
    assign beep       = beep_q;
    assign state      = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit
// Directed testbench for alarm_unit: walks through setting, arming,
// ringing with beep, snooze, coincident snooze/dismiss, retrigger rules,
// unattended timeout, disarm while ringing and reset with a held button.
module tb_alarm_unit;

    logic        clk;
    logic        reset;
    logic [26:0] cur_time;
    logic        set_en, add_one, add_ten, hr_sw, min_sw, arm, snooze, dismiss;
    logic [26:0] alarm_time;
    logic        armed, ringing, beep;
    logic [1:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    alarm_unit dut (
        .clk        (clk),
        .reset      (reset),
        .cur_time   (cur_time),
        .set_en     (set_en),
        .add_one    (add_one),
        .add_ten    (add_ten),
        .hr_sw      (hr_sw),
        .min_sw     (min_sw),
        .arm        (arm),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .alarm_time (alarm_time),
        .armed      (armed),
        .ringing    (ringing),
        .beep       (beep),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs hour/minute/second into the clock's time word.
    function automatic logic [26:0] mk(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        return {h, m, s, 10'b0};
    endfunction

    // Advances n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseAdd(input logic one, input logic ten);
        add_one = one;
        add_ten = ten;
        applyStimulus(1);
        add_one = 1'b0;
        add_ten = 1'b0;
        applyStimulus(1);
    endtask

    initial begin
        reset = 1'b1;
        cur_time = '0;
        set_en = 0; add_one = 0; add_ten = 0; hr_sw = 0; min_sw = 0;
        arm = 0; snooze = 0; dismiss = 0;
        applyStimulus(2);
        checkOutput("reset_alarm_time", alarm_time, 27'd0);
        checkOutput("reset_state", 27'(state), 27'd0);
        checkOutput("reset_armed", 27'(armed), 27'd0);
        checkOutput("reset_ringing", 27'(ringing), 27'd0);
        checkOutput("reset_beep", 27'(beep), 27'd0);
        reset = 1'b0;
        applyStimulus(1);

        // Hour: 0 -> 10 -> 20 -> 6 via three +10 pulses.
        set_en = 1; hr_sw = 1;
        pulseAdd(0, 1);
        checkOutput("set_hr_10", 27'(alarm_time[26:22]), 27'd10);
        pulseAdd(0, 1);
        checkOutput("set_hr_20", 27'(alarm_time[26:22]), 27'd20);
        pulseAdd(0, 1);
        checkOutput("set_hr_wrap_6", 27'(alarm_time[26:22]), 27'd6);

        // Minute: simultaneous edges give +11.
        hr_sw = 0; min_sw = 1;
        pulseAdd(1, 1);
        checkOutput("set_min_11", alarm_time, mk(5'd6, 6'd11, 6'd0));

        // Arm at 06:10:59.
        min_sw = 0; set_en = 0;
        cur_time = mk(5'd6, 6'd10, 6'd59);
        arm = 1;
        applyStimulus(1);
        checkOutput("armed_state", 27'(state), 27'd1);
        checkOutput("armed_flag", 27'(armed), 27'd1);

        // Setting is locked while armed.
        set_en = 1; hr_sw = 1;
        pulseAdd(1, 0);
        checkOutput("locked_alarm_time", alarm_time, mk(5'd6, 6'd11, 6'd0));
        checkOutput("locked_state", 27'(state), 27'd1);
        set_en = 0; hr_sw = 0;

        // Entering 06:11 rings one cycle later.
        cur_time = mk(5'd6, 6'd11, 6'd0);
        checkOutput("pre_ring_ringing", 27'(ringing), 27'd0);
        applyStimulus(1);
        checkOutput("ring_ringing", 27'(ringing), 27'd1);
        checkOutput("ring_beep_start", 27'(beep), 27'd1);
        applyStimulus(249);
        checkOutput("beep_high_last", 27'(beep), 27'd1);
        applyStimulus(1);
        checkOutput("beep_low_first", 27'(beep), 27'd0);
        applyStimulus(249);
        checkOutput("beep_low_last", 27'(beep), 27'd0);
        applyStimulus(1);
        checkOutput("beep_high_again", 27'(beep), 27'd1);

        // Snooze for five minute changes.
        snooze = 1;
        applyStimulus(1);
        snooze = 0;
        checkOutput("snooze_state", 27'(state), 27'd3);
        checkOutput("snooze_beep", 27'(beep), 27'd0);
        applyStimulus(1);
        for (int m = 12; m <= 15; m++) begin
            cur_time = mk(5'd6, 6'(m), 6'd0);
            applyStimulus(1);
        end
        checkOutput("snooze_4min_state", 27'(state), 27'd3);
        cur_time = mk(5'd6, 6'd16, 6'd0);
        applyStimulus(1);
        checkOutput("snooze_done_state", 27'(state), 27'd2);
        checkOutput("snooze_done_ringing", 27'(ringing), 27'd1);

        // Back inside 06:11 while ringing (ignored trigger), then snooze+dismiss together.
        cur_time = mk(5'd6, 6'd11, 6'd0);
        applyStimulus(1);
        checkOutput("ring_ignores_trigger", 27'(state), 27'd2);
        snooze = 1; dismiss = 1;
        applyStimulus(1);
        snooze = 0; dismiss = 0;
        checkOutput("dismiss_wins_state", 27'(state), 27'd1);
        cur_time = mk(5'd6, 6'd11, 6'd30);
        applyStimulus(5);
        checkOutput("no_retrigger", 27'(state), 27'd1);

        // Leave and re-enter the alarm minute.
        cur_time = mk(5'd6, 6'd12, 6'd0);
        applyStimulus(1);
        cur_time = mk(5'd6, 6'd11, 6'd0);
        applyStimulus(1);
        checkOutput("reenter_ringing", 27'(ringing), 27'd1);

        // Unattended: ten minute changes stop the ring.
        for (int m = 12; m <= 20; m++) begin
            cur_time = mk(5'd6, 6'(m), 6'd0);
            applyStimulus(1);
        end
        checkOutput("timeout_9min_state", 27'(state), 27'd2);
        cur_time = mk(5'd6, 6'd21, 6'd0);
        applyStimulus(1);
        checkOutput("timeout_state", 27'(state), 27'd1);
        checkOutput("timeout_ringing", 27'(ringing), 27'd0);
        checkOutput("timeout_beep", 27'(beep), 27'd0);

        // Ring again, then drop arm.
        cur_time = mk(5'd6, 6'd11, 6'd0);
        applyStimulus(1);
        checkOutput("ring_before_disarm", 27'(state), 27'd2);
        arm = 0;
        applyStimulus(1);
        checkOutput("disarm_state", 27'(state), 27'd0);
        checkOutput("disarm_armed", 27'(armed), 27'd0);
        checkOutput("disarm_beep", 27'(beep), 27'd0);

        // Reset with add_one held: no edge after release.
        set_en = 1; hr_sw = 1; add_one = 1;
        reset = 1;
        applyStimulus(1);
        checkOutput("reset2_alarm_time", alarm_time, 27'd0);
        reset = 0;
        applyStimulus(2);
        checkOutput("held_button_no_inc", alarm_time, 27'd0);
        add_one = 0;
        applyStimulus(1);
        pulseAdd(1, 0);
        checkOutput("post_reset_inc", 27'(alarm_time[26:22]), 27'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
